timer_counter8: RTL and testbench



---
 rtl/timer_pkg.sv | 18 +
 rtl/edge_rise_det.sv | 22 ++
 rtl/timer_counter8.sv | 88 ++++++++
 tb/tb_timer_counter8.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the timer blocks: width, direction encodings,
// prescaler select codes and the counter limits.
package timer_pkg;

   localparam int TIMER_WIDTH = 8;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   localparam logic [1:0] CKS_DIV2  = 2'b00;
   localparam logic [1:0] CKS_DIV4  = 2'b01;
   localparam logic [1:0] CKS_DIV8  = 2'b10;
   localparam logic [1:0] CKS_DIV16 = 2'b11;

   localparam logic [TIMER_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [TIMER_WIDTH-1:0] CNT_MIN = '0;

endpackage

// File: rtl/edge_rise_det.sv
// One-cycle strobe on each rising edge of a pclk-derived level.
// No synchroniser: d must already be in the pclk domain.
module edge_rise_det (
   input  logic pclk,
   input  logic presetn,
   input  logic d,
   output logic rise
);

   logic d_q;
   logic d_d;

   always_comb d_d = d;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) d_q <= 1'b0;
      else          d_q <= d_d;
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/timer_counter8.sv
// Up/down timer count core with sticky ovf/udf flags and registered irq.
// Define TIMER_AUTO_RELOAD_EN to reload cnt from tdr on overflow/underflow.
module timer_counter8
   import timer_pkg::*;
#(
   parameter int               WIDTH   = TIMER_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             pclk,
   input  logic             presetn,
   input  logic             clk_in,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] tdr,
   input  logic             clr_ovf,
   input  logic             clr_udf,
   input  logic             ovie,
   input  logic             udie,
   output logic [WIDTH-1:0] cnt,
   output logic             ovf,
   output logic             udf,
   output logic             irq
);

   logic             tick;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             irq_q, irq_d;
   logic             wrap;

   edge_rise_det u_rise (
      .pclk    (pclk),
      .presetn (presetn),
      .d       (clk_in),
      .rise    (tick)
   );

   always_comb begin
      cnt_d = cnt_q;
      wrap  = 1'b0;
      // Clear first so a same-cycle set event wins.
      ovf_d = ovf_q & ~clr_ovf;
      udf_d = udf_q & ~clr_udf;
      if (load) begin
         cnt_d = tdr;
      end else if (en && tick) begin
         if (dir == DIR_UP) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {WIDTH{1'b1}}) begin
               wrap  = 1'b1;
               ovf_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == {WIDTH{1'b0}}) begin
               wrap  = 1'b1;
               udf_d = 1'b1;
            end
         end
`ifdef TIMER_AUTO_RELOAD_EN
         if (wrap) cnt_d = tdr;
`endif
      end
      irq_d = (ovf_d & ovie) | (udf_d & udie);
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         cnt_q <= RST_VAL;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
         irq_q <= irq_d;
      end
   end

   assign cnt = cnt_q;
   assign ovf = ovf_q;
   assign udf = udf_q;
   assign irq = irq_q;

endmodule

// File: tb/tb_timer_counter8.sv
// Randomised + directed bench for timer_counter8 against an integer reference model.
module tb_timer_counter8;

   logic       pclk, presetn, clk_in, en, dir, load, clr_ovf, clr_udf, ovie, udie;
   logic [7:0] tdr, cnt;
   logic       ovf, udf, irq;

   timer_counter8 dut (
      .pclk(pclk), .presetn(presetn), .clk_in(clk_in), .en(en), .dir(dir),
      .load(load), .tdr(tdr), .clr_ovf(clr_ovf), .clr_udf(clr_udf),
      .ovie(ovie), .udie(udie), .cnt(cnt), .ovf(ovf), .udf(udf), .irq(irq)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int checks = 0;
   int failures = 0;

   // reference state: count as a plain integer in 0..255
   int m_cnt;
   bit m_ovf, m_udf, m_irq, m_prev;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_ovf = 0; m_udf = 0; m_irq = 0; m_prev = 0;
   endtask

   task automatic model_edge();
      bit rise_ev, ov_ev, ud_ev;
      rise_ev = clk_in && !m_prev;
      m_prev  = clk_in;
      ov_ev = 0; ud_ev = 0;
      if (load) m_cnt = tdr;
      else if (en && rise_ev) begin
         if (!dir) begin
            ov_ev = (m_cnt == 255);
            m_cnt = (m_cnt + 1) % 256;
         end else begin
            ud_ev = (m_cnt == 0);
            m_cnt = (m_cnt + 255) % 256;
         end
`ifdef TIMER_AUTO_RELOAD_EN
         if (ov_ev || ud_ev) m_cnt = tdr;
`endif
      end
      m_ovf = ov_ev || (m_ovf && !clr_ovf);
      m_udf = ud_ev || (m_udf && !clr_udf);
      m_irq = (m_ovf && ovie) || (m_udf && udie);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".cnt"}, 32'(cnt), 32'(m_cnt));
      chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
      chk({tag, ".udf"}, 32'(udf), 32'(m_udf));
      chk({tag, ".irq"}, 32'(irq), 32'(m_irq));
   endtask

   // one pclk cycle: model advances on the edge, outputs compared 1ns later
   task automatic step(input string tag);
      @(posedge pclk);
      if (!presetn) model_reset();
      else          model_edge();
      #1;
      check_all(tag);
   endtask

   // n periods of a pclk/div clock on clk_in, high for the first half
   task automatic run_div(input int div, input int n, input string tag);
      for (int i = 0; i < n * div; i++) begin
         clk_in = ((i % div) < div / 2);
         step(tag);
      end
      clk_in = 1'b0;
   endtask

   task automatic do_load(input logic [7:0] v);
      load = 1'b1; tdr = v;
      step("load");
      load = 1'b0;
   endtask

   initial begin
      presetn = 0; clk_in = 0; en = 0; dir = 0; load = 0; tdr = 0;
      clr_ovf = 0; clr_udf = 0; ovie = 0; udie = 0;
      model_reset();
      #1;
      check_all("rst0");
      step("rst"); step("rst");
      #2 presetn = 1;

      // mid-count asynchronous reset
      en = 1; dir = 0; ovie = 1;
      do_load(8'h37);
      run_div(2, 2, "pre_rst");
      #2 presetn = 0;
      #1;
      model_reset();
      chk("arst.cnt", 32'(cnt), 32'h0);
      check_all("arst");
      step("arst_hold");
      #2 presetn = 1;
      clk_in = 1'b0;
      step("release");

      // up count through overflow at pclk/2
      en = 1; dir = 0; ovie = 1; udie = 1;
      do_load(8'hFD);
      run_div(2, 3, "up");
      chk("up.wrap_cnt", 32'(cnt), 32'h00);
      chk("up.ovf", 32'(ovf), 32'h1);
      chk("up.irq", 32'(irq), 32'h1);

      // down count through underflow at pclk/8
      clr_ovf = 1; step("clr"); clr_ovf = 0;
      dir = 1;
      do_load(8'h01);
      run_div(8, 2, "down");
      chk("down.cnt", 32'(cnt), 32'hFF);
      chk("down.udf", 32'(udf), 32'h1);

      // clear coincident with a new underflow: set wins
      do_load(8'h00);
      clk_in = 0; step("sc0");
      clk_in = 1; clr_udf = 1; step("sc1");
      clr_udf = 0; clk_in = 0;
      chk("setclr.udf", 32'(udf), 32'h1);
      clr_udf = 1; step("clr_udf"); clr_udf = 0;

      // load beats a same-cycle tick, then hold while disabled
      dir = 0;
      clk_in = 0; step("lp0");
      clk_in = 1; load = 1; tdr = 8'h80; step("lp1");
      load = 0;
      chk("loadprio.cnt", 32'(cnt), 32'h80);
      en = 0;
      run_div(2, 10, "hold");
      clk_in = 1; step("hold_hi");
      en = 1; step("reen"); step("reen2");
      chk("reen.cnt", 32'(cnt), 32'h80);
      clk_in = 0; step("reen3");

      // flag clear drops irq; ovie=0 keeps irq low
      ovie = 1;
      do_load(8'hFF);
      run_div(2, 1, "ov1");
      chk("ovf_set", 32'(ovf), 32'h1);
      clr_ovf = 1; step("clr_ovf"); clr_ovf = 0;
      chk("clr.ovf", 32'(ovf), 32'h0);
      step("clr_after");
      chk("clr.irq", 32'(irq), 32'h0);
      ovie = 0;
      do_load(8'hFF);
      run_div(2, 1, "ov2");
      chk("noie.irq", 32'(irq), 32'h0);
      clr_ovf = 1; step("clr2"); clr_ovf = 0;

      // reload versus wrap at the top
      ovie = 1; dir = 0;
      do_load(8'hFC);
      run_div(4, 4, "ar");
`ifdef TIMER_AUTO_RELOAD_EN
      chk("ar.cnt", 32'(cnt), 32'hFC);
`else
      chk("ar.cnt", 32'(cnt), 32'h00);
`endif
      chk("ar.ovf", 32'(ovf), 32'h1);

      // randomised traffic
      for (int i = 0; i < 1500; i++) begin
         clk_in  = 1'($urandom_range(0, 1));
         en      = ($urandom_range(0, 7) != 0);
         dir     = 1'($urandom_range(0, 1));
         load    = ($urandom_range(0, 15) == 0);
         tdr     = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
         clr_ovf = ($urandom_range(0, 11) == 0);
         clr_udf = ($urandom_range(0, 11) == 0);
         ovie    = ($urandom_range(0, 3) != 0);
         udie    = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 6) == 0) tdr = 8'h01;
         step("rand");
      end
      load = 0; clr_ovf = 0; clr_udf = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
